// File: rtl/mac_issue_pkg.sv
// rtl/mac_issue_pkg.sv - shared types and constants for the MAC issue controller
package mac_issue_pkg;

  // Field widths of a buffered instruction; the controller parameters default to these.
  localparam int MAC_ID_W = 3;
  localparam int MAC_XLEN = 32;
  localparam int MAC_OP_W = 2;

  // MAC operation codes; passed through to the datapath untouched.
  localparam logic [MAC_OP_W-1:0] OP_MUL  = 2'd0;
  localparam logic [MAC_OP_W-1:0] OP_MULH = 2'd1;
  localparam logic [MAC_OP_W-1:0] OP_MAC  = 2'd2;
  localparam logic [MAC_OP_W-1:0] OP_MSU  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [MAC_ID_W-1:0] id;
    logic [4:0]          rd;
    logic [MAC_OP_W-1:0] op;
    logic [MAC_XLEN-1:0] rs1;
    logic [MAC_XLEN-1:0] rs2;
    logic                committed;
    logic                killed;
  } entry_t;

endpackage

// File: rtl/mac_issue_fifo.sv
// rtl/mac_issue_fifo.sv - in-order pending-instruction buffer with commit/kill update
module mac_issue_fifo
  import mac_issue_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  entry_t              push_data_i,
  input  logic                pop_i,
  input  logic                commit_valid_i,
  input  logic [MAC_ID_W-1:0] commit_id_i,
  input  logic                commit_kill_i,
  output entry_t              head_o,
  output logic                head_valid_o,
  output logic                full_o,
  output logic                empty_o
);

  localparam int PtrW = $clog2(Depth);

  entry_t            mem_q [Depth];
  logic [Depth-1:0]  valid_q;
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [PtrW:0]     count_q;
  entry_t            push_entry;
  logic              push_hit;

  // A commit for the id being pushed this cycle lands on the new entry.
  always_comb begin
    push_hit             = commit_valid_i && (push_data_i.id == commit_id_i);
    push_entry           = push_data_i;
    push_entry.committed = push_data_i.committed | (push_hit & ~commit_kill_i);
    push_entry.killed    = push_data_i.killed    | (push_hit &  commit_kill_i);
  end

  // Storage, pointers and occupancy; only unresolved entries take a commit/kill,
  // so a head already running on the MAC cannot be killed underneath it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (valid_q[i] && commit_valid_i && (mem_q[i].id == commit_id_i) &&
            !mem_q[i].committed && !mem_q[i].killed) begin
          if (commit_kill_i) mem_q[i].killed <= 1'b1;
          else               mem_q[i].committed <= 1'b1;
        end
      end
      if (push_i) begin
        mem_q[wr_ptr_q]   <= push_entry;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PtrW'(1);
      end
      if (pop_i) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PtrW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Flags come straight from registered occupancy, so a pop does not free a slot
  // for the issue side until the following cycle.
  always_comb begin
    head_o       = mem_q[rd_ptr_q];
    head_valid_o = valid_q[rd_ptr_q];
    full_o       = (count_q == (PtrW+1)'(Depth));
    empty_o      = (count_q == '0);
  end

endmodule

// File: rtl/mac_issue_ctrl.sv
// rtl/mac_issue_ctrl.sv - CV-X-IF MAC issue/commit/result sequencer (optional MAC_ISSUE_PERF_EN counters)
module mac_issue_ctrl
  import mac_issue_pkg::*;
#(
  parameter int Depth   = 4,
  parameter int IdWidth = MAC_ID_W,
  parameter int XLen    = MAC_XLEN,
  parameter int OpWidth = MAC_OP_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  input  logic               issue_accept_i,
  output logic               issue_ready_o,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [4:0]         issue_rd_i,
  input  logic [OpWidth-1:0] issue_op_i,
  input  logic [XLen-1:0]    issue_rs1_i,
  input  logic [XLen-1:0]    issue_rs2_i,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               mac_start_o,
  output logic [OpWidth-1:0] mac_op_o,
  output logic [XLen-1:0]    mac_rs1_o,
  output logic [XLen-1:0]    mac_rs2_o,
  input  logic               mac_done_i,
  input  logic [XLen-1:0]    mac_result_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [4:0]         result_rd_o,
  output logic [XLen-1:0]    result_data_o,
`ifdef MAC_ISSUE_PERF_EN
  output logic [31:0]        perf_exec_cnt_o,
  output logic [31:0]        perf_stall_cnt_o,
`endif
  output logic               busy_o
);

  // Entry field widths are those of mac_issue_pkg; the parameters mirror them.
  state_e  state_q, state_d;
  entry_t  push_entry;
  entry_t  head;
  logic    head_valid;
  logic    full, empty;
  logic    push, pop;
  logic [XLen-1:0] result_q;

  // Pack the issue request into a buffer entry; commit flags are merged in the buffer.
  always_comb begin
    push                 = issue_valid_i && issue_accept_i && !full;
    push_entry.id        = issue_id_i;
    push_entry.rd        = issue_rd_i;
    push_entry.op        = issue_op_i;
    push_entry.rs1       = issue_rs1_i;
    push_entry.rs2       = issue_rs2_i;
    push_entry.committed = 1'b0;
    push_entry.killed    = 1'b0;
  end

  mac_issue_fifo #(.Depth(Depth)) u_fifo (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .push_i         (push),
    .push_data_i    (push_entry),
    .pop_i          (pop),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .head_o         (head),
    .head_valid_o   (head_valid),
    .full_o         (full),
    .empty_o        (empty)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Head-of-queue sequencing: drop killed entries, start committed ones, hold the result.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    mac_start_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (head_valid) begin
          if (head.killed) begin
            pop = 1'b1;
          end else if (head.committed) begin
            mac_start_o = 1'b1;
            state_d     = EXEC;
          end
        end
      end
      EXEC: begin
        if (mac_done_i) state_d = RESP;
      end
      RESP: begin
        if (result_ready_i) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the MAC result; done pulses outside EXEC are ignored.
  always_ff @(posedge clk_i) begin
    if (rst_i)                              result_q <= '0;
    else if (state_q == EXEC && mac_done_i) result_q <= mac_result_i;
  end

  // Head stays in the buffer until the result handshake, keeping operands and fields stable.
  always_comb begin
    issue_ready_o  = !full;
    mac_op_o       = head_valid ? head.op  : '0;
    mac_rs1_o      = head_valid ? head.rs1 : '0;
    mac_rs2_o      = head_valid ? head.rs2 : '0;
    result_valid_o = (state_q == RESP);
    result_id_o    = result_valid_o ? head.id : '0;
    result_rd_o    = result_valid_o ? head.rd : '0;
    result_data_o  = result_valid_o ? result_q : '0;
    busy_o         = !empty || (state_q != IDLE);
  end

`ifdef MAC_ISSUE_PERF_EN
  // Saturating cycle counters for MAC occupancy and issue stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_exec_cnt_o  <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (state_q == EXEC && perf_exec_cnt_o != '1)
        perf_exec_cnt_o <= perf_exec_cnt_o + 32'd1;
      if (issue_valid_i && issue_accept_i && !issue_ready_o && perf_stall_cnt_o != '1)
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_issue_ctrl.sv
// tb/tb_mac_issue_ctrl.sv - directed self-checking bench for mac_issue_ctrl
module tb_mac_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i, issue_accept_i, issue_ready_o;
  logic [2:0]  issue_id_i;
  logic [4:0]  issue_rd_i;
  logic [1:0]  issue_op_i;
  logic [31:0] issue_rs1_i, issue_rs2_i;
  logic        commit_valid_i, commit_kill_i;
  logic [2:0]  commit_id_i;
  logic        mac_start_o;
  logic [1:0]  mac_op_o;
  logic [31:0] mac_rs1_o, mac_rs2_o;
  logic        mac_done_i;
  logic [31:0] mac_result_i;
  logic        result_valid_o, result_ready_i;
  logic [2:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic [31:0] result_data_o;
  logic        busy_o;
`ifdef MAC_ISSUE_PERF_EN
  logic [31:0] perf_exec_cnt_o, perf_stall_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;
  int res_cnt = 0;
  int s0, r0;

  mac_issue_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .issue_valid_i  (issue_valid_i),
    .issue_accept_i (issue_accept_i),
    .issue_ready_o  (issue_ready_o),
    .issue_id_i     (issue_id_i),
    .issue_rd_i     (issue_rd_i),
    .issue_op_i     (issue_op_i),
    .issue_rs1_i    (issue_rs1_i),
    .issue_rs2_i    (issue_rs2_i),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .mac_start_o    (mac_start_o),
    .mac_op_o       (mac_op_o),
    .mac_rs1_o      (mac_rs1_o),
    .mac_rs2_o      (mac_rs2_o),
    .mac_done_i     (mac_done_i),
    .mac_result_i   (mac_result_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_id_o    (result_id_o),
    .result_rd_o    (result_rd_o),
    .result_data_o  (result_data_o),
`ifdef MAC_ISSUE_PERF_EN
    .perf_exec_cnt_o  (perf_exec_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o),
`endif
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Count start pulses and result-valid cycles as seen at each clock edge.
  always @(posedge clk_i) begin
    if (mac_start_o)    start_cnt++;
    if (result_valid_o) res_cnt++;
  end

  task step();
    @(posedge clk_i);
    #1;
  endtask

  task drive_idle();
    issue_valid_i  = 1'b0;
    issue_accept_i = 1'b0;
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
    mac_done_i     = 1'b0;
    result_ready_i = 1'b0;
  endtask

  task drive_issue(input logic [2:0] id, input logic [4:0] rd, input logic [1:0] op,
                   input logic [31:0] a, input logic [31:0] b);
    issue_valid_i  = 1'b1;
    issue_accept_i = 1'b1;
    issue_id_i     = id;
    issue_rd_i     = rd;
    issue_op_i     = op;
    issue_rs1_i    = a;
    issue_rs2_i    = b;
  endtask

  task drive_commit(input logic [2:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
  endtask

  // Called in the cycle mac_start_o is high: run EXEC, return result, accept it.
  task run_op(input logic [31:0] res);
    step();
    mac_done_i   = 1'b1;
    mac_result_i = res;
    step();
    mac_done_i     = 1'b0;
    result_ready_i = 1'b1;
    step();
    result_ready_i = 1'b0;
  endtask

  task test_reset();
    rst_i = 1'b1;
    drive_idle();
    issue_id_i = '0; issue_rd_i = '0; issue_op_i = '0;
    issue_rs1_i = '0; issue_rs2_i = '0;
    commit_id_i = '0; mac_result_i = '0;
    step();
    step();
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if ({busy_o, result_valid_o, mac_start_o} !== 3'b000) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 000", {busy_o, result_valid_o, mac_start_o});
    end
    n_cmp++;
    if ({mac_rs1_o, result_data_o, result_id_o} !== 67'd0) begin
      n_err++; $display("FAIL reset_data: got rs1=%0d data=%0d id=%0d want 0", mac_rs1_o, result_data_o, result_id_o);
    end
  endtask

  task test_basic();
    step();
    drive_issue(3'd1, 5'd5, 2'd0, 32'd3, 32'd4);
    #1;
    n_cmp++;
    if (issue_ready_o !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b want 1", issue_ready_o); end
    step();
    drive_idle();
    drive_commit(3'd1, 1'b0);
    #1;
    n_cmp++;
    if (mac_start_o !== 1'b0) begin n_err++; $display("FAIL basic_nostart: got %b want 0", mac_start_o); end
    step();
    drive_idle();
    #1;
    n_cmp++;
    if ({mac_start_o, mac_op_o, mac_rs1_o, mac_rs2_o, busy_o} !== {1'b1, 2'd0, 32'd3, 32'd4, 1'b1}) begin
      n_err++; $display("FAIL basic_start: got start=%b op=%0d rs1=%0d rs2=%0d want 1 0 3 4", mac_start_o, mac_op_o, mac_rs1_o, mac_rs2_o);
    end
    step();
    #1;
    n_cmp++;
    if ({mac_start_o, mac_rs1_o} !== {1'b0, 32'd3}) begin
      n_err++; $display("FAIL basic_exec: got start=%b rs1=%0d want 0 3", mac_start_o, mac_rs1_o);
    end
    mac_done_i   = 1'b1;
    mac_result_i = 32'd12;
    step();
    mac_done_i = 1'b0;
    #1;
    n_cmp++;
    if ({result_valid_o, result_id_o, result_rd_o, result_data_o} !== {1'b1, 3'd1, 5'd5, 32'd12}) begin
      n_err++; $display("FAIL basic_result: got v=%b id=%0d rd=%0d data=%0d want 1 1 5 12", result_valid_o, result_id_o, result_rd_o, result_data_o);
    end
    result_ready_i = 1'b1;
    step();
    result_ready_i = 1'b0;
    #1;
    n_cmp++;
    if ({result_valid_o, busy_o} !== 2'b00) begin
      n_err++; $display("FAIL basic_done: got v=%b busy=%b want 0 0", result_valid_o, busy_o);
    end
  endtask

  task test_same_cycle_commit();
    step();
    drive_issue(3'd4, 5'd7, 2'd2, 32'd10, 32'd11);
    drive_commit(3'd4, 1'b0);
    #1;
    n_cmp++;
    if (mac_start_o !== 1'b0) begin n_err++; $display("FAIL same_early: got %b want 0", mac_start_o); end
    step();
    drive_idle();
    #1;
    n_cmp++;
    if ({mac_start_o, mac_op_o, mac_rs1_o} !== {1'b1, 2'd2, 32'd10}) begin
      n_err++; $display("FAIL same_start: got start=%b op=%0d rs1=%0d want 1 2 10", mac_start_o, mac_op_o, mac_rs1_o);
    end
    run_op(32'd110);
    drive_issue(3'd3, 5'd1, 2'd1, 32'd5, 32'd6);
    step();
    drive_idle();
    drive_commit(3'd7, 1'b0);
    step();
    drive_idle();
    #1;
    n_cmp++;
    if ({mac_start_o, busy_o} !== 2'b01) begin
      n_err++; $display("FAIL unknown_id: got start=%b busy=%b want 0 1", mac_start_o, busy_o);
    end
    drive_commit(3'd3, 1'b0);
    step();
    drive_idle();
    #1;
    n_cmp++;
    if ({mac_start_o, mac_rs2_o} !== {1'b1, 32'd6}) begin
      n_err++; $display("FAIL known_id: got start=%b rs2=%0d want 1 6", mac_start_o, mac_rs2_o);
    end
    run_op(32'd30);
  endtask

  task test_full();
    s0 = start_cnt;
    r0 = res_cnt;
    for (int i = 0; i < 4; i++) begin
      step();
      drive_issue(3'(i), 5'(i + 1), 2'd0, 32'(i + 8), 32'd1);
      #1;
      n_cmp++;
      if (issue_ready_o !== 1'b1) begin n_err++; $display("FAIL fill_ready%0d: got %b want 1", i, issue_ready_o); end
    end
    step();
    drive_issue(3'd4, 5'd9, 2'd0, 32'd99, 32'd99);
    #1;
    n_cmp++;
    if (issue_ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", issue_ready_o); end
    step();
    step();
    #1;
    n_cmp++;
    if ({issue_ready_o, busy_o, start_cnt} !== {1'b0, 1'b1, s0}) begin
      n_err++; $display("FAIL full_stall: got ready=%b busy=%b starts=%0d want 0 1 %0d", issue_ready_o, busy_o, start_cnt, s0);
    end
    drive_idle();
    drive_commit(3'd0, 1'b0);
    step();
    drive_idle();
    #1;
    n_cmp++;
    if ({mac_start_o, mac_rs1_o} !== {1'b1, 32'd8}) begin
      n_err++; $display("FAIL full_start: got start=%b rs1=%0d want 1 8", mac_start_o, mac_rs1_o);
    end
    step();
    #1;
    n_cmp++;
    if (start_cnt !== s0 + 1) begin n_err++; $display("FAIL full_one_start: got %0d want %0d", start_cnt, s0 + 1); end
    mac_done_i   = 1'b1;
    mac_result_i = 32'd1;
    step();
    mac_done_i     = 1'b0;
    result_ready_i = 1'b1;
    #1;
    n_cmp++;
    if (issue_ready_o !== 1'b0) begin n_err++; $display("FAIL full_pop_ready: got %b want 0", issue_ready_o); end
    step();
    result_ready_i = 1'b0;
    #1;
    n_cmp++;
    if ({issue_ready_o, mac_start_o} !== 2'b10) begin
      n_err++; $display("FAIL after_pop: got ready=%b start=%b want 1 0", issue_ready_o, mac_start_o);
    end
    drive_commit(3'd1, 1'b1);
    step();
    drive_commit(3'd2, 1'b1);
    step();
    drive_commit(3'd3, 1'b1);
    step();
    drive_idle();
    step(); step(); step(); step();
    n_cmp++;
    if ({busy_o, start_cnt, res_cnt} !== {1'b0, s0 + 1, r0 + 1}) begin
      n_err++; $display("FAIL full_drain: got busy=%b starts=%0d results=%0d want 0 %0d %0d", busy_o, start_cnt, res_cnt, s0 + 1, r0 + 1);
    end
  endtask

  task test_kill();
    s0 = start_cnt;
    r0 = res_cnt;
    step();
    drive_issue(3'd2, 5'd4, 2'd1, 32'd1, 32'd2);
    step();
    drive_idle();
    drive_commit(3'd2, 1'b1);
    #1;
    n_cmp++;
    if (busy_o !== 1'b1) begin n_err++; $display("FAIL kill_busy: got %b want 1", busy_o); end
    step();
    drive_idle();
    step();
    n_cmp++;
    if ({busy_o, start_cnt, res_cnt} !== {1'b0, s0, r0}) begin
      n_err++; $display("FAIL kill_drop: got busy=%b starts=%0d results=%0d want 0 %0d %0d", busy_o, start_cnt, res_cnt, s0, r0);
    end
  endtask

  task test_backpressure();
    step();
    drive_issue(3'd5, 5'd9, 2'd1, 32'd7, 32'd6);
    drive_commit(3'd5, 1'b0);
    step();
    drive_issue(3'd6, 5'd3, 2'd3, 32'd2, 32'd10);
    drive_commit(3'd6, 1'b0);
    #1;
    n_cmp++;
    if ({mac_start_o, mac_rs1_o} !== {1'b1, 32'd7}) begin
      n_err++; $display("FAIL bp_start: got start=%b rs1=%0d want 1 7", mac_start_o, mac_rs1_o);
    end
    step();
    drive_idle();
    mac_done_i   = 1'b1;
    mac_result_i = 32'd42;
    step();
    mac_done_i = 1'b0;
    s0 = start_cnt;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if ({result_valid_o, result_id_o, result_rd_o, result_data_o} !== {1'b1, 3'd5, 5'd9, 32'd42}) begin
        n_err++; $display("FAIL bp_hold%0d: got v=%b id=%0d rd=%0d data=%0d want 1 5 9 42", k, result_valid_o, result_id_o, result_rd_o, result_data_o);
      end
      step();
    end
    n_cmp++;
    if (start_cnt !== s0) begin n_err++; $display("FAIL bp_nostart: got %0d want %0d", start_cnt, s0); end
    result_ready_i = 1'b1;
    step();
    result_ready_i = 1'b0;
    #1;
    n_cmp++;
    if ({mac_start_o, mac_op_o, mac_rs1_o, mac_rs2_o} !== {1'b1, 2'd3, 32'd2, 32'd10}) begin
      n_err++; $display("FAIL bp_next: got start=%b op=%0d rs1=%0d rs2=%0d want 1 3 2 10", mac_start_o, mac_op_o, mac_rs1_o, mac_rs2_o);
    end
    run_op(32'd20);
  endtask

  task test_reset_exec();
    step();
    drive_issue(3'd3, 5'd2, 2'd0, 32'd9, 32'd9);
    drive_commit(3'd3, 1'b0);
    step();
    drive_idle();
    #1;
    n_cmp++;
    if (mac_start_o !== 1'b1) begin n_err++; $display("FAIL rst_pre_start: got %b want 1", mac_start_o); end
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if ({busy_o, result_valid_o, mac_start_o, mac_rs1_o, result_id_o} !== 38'd0) begin
      n_err++; $display("FAIL rst_exec: got busy=%b v=%b start=%b rs1=%0d want all 0", busy_o, result_valid_o, mac_start_o, mac_rs1_o);
    end
    r0 = res_cnt;
    mac_done_i   = 1'b1;
    mac_result_i = 32'd99;
    step();
    mac_done_i = 1'b0;
    step();
    step();
    n_cmp++;
    if ({result_valid_o, busy_o, result_data_o, res_cnt} !== {1'b0, 1'b0, 32'd0, r0}) begin
      n_err++; $display("FAIL rst_late_done: got v=%b busy=%b data=%0d results=%0d want 0 0 0 %0d", result_valid_o, busy_o, result_data_o, res_cnt, r0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_same_cycle_commit();
    test_full();
    test_kill();
    test_backpressure();
    test_reset_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
